// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush/PC-select,
// return-stack strobes with depth tracking, and EX operand forwarding selects.
module pipe_hazard_ctrl #(
   parameter int STACK_DEPTH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [2:0]       id_src_a,
   input  logic [2:0]       id_src_b,
   input  logic             id_use_a,
   input  logic             id_use_b,
   input  logic             id_branch,
   input  logic             id_jump,
   input  logic             id_call,
   input  logic             id_ret,
   input  logic             id_uses_flags,
   input  logic             branch_taken,
   input  logic [2:0]       ex_rd,
   input  logic [2:0]       mem_rd,
   input  logic [2:0]       wb_rd,
   input  logic             ex_reg_write,
   input  logic             mem_reg_write,
   input  logic             wb_reg_write,
   input  logic             ex_is_load,
   input  logic             ex_writes_flags,
   input  logic [2:0]       ex_src_a,
   input  logic [2:0]       ex_src_b,
   input  logic             ex_use_imm,
   output logic             pc_writebar,
   output logic             IF_ID_loadbar,
   output logic             ID_EX_flush,
   output logic             IF_ID_flush,
   output logic [1:0]       pc_mux,
   output logic             push,
   output logic             pop,
   output logic [1:0]       forward_A,
   output logic [1:0]       forward_B,
   output logic             stack_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

   typedef enum logic [1:0] {ST_RUN, ST_REDIR, ST_HALT} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use, flag_haz;

   assign load_use = id_valid && ex_is_load && ex_reg_write &&
                     ((id_use_a && (id_src_a == ex_rd)) || (id_use_b && (id_src_b == ex_rd)));
   assign flag_haz = id_valid && id_branch && id_uses_flags && ex_writes_flags;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         depth_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      depth_d       = depth_q;
      err_d         = err_q;
      cnt_d         = cnt_q;
      pc_writebar   = 1'b0;
      IF_ID_loadbar = 1'b0;
      ID_EX_flush   = 1'b0;
      IF_ID_flush   = 1'b0;
      pc_mux        = 2'b00;
      push          = 1'b0;
      pop           = 1'b0;
      forward_A     = 2'b00;
      forward_B     = 2'b00;

      case (state_q)
         ST_RUN: begin
            if (load_use || flag_haz) begin
               pc_writebar   = 1'b1;
               IF_ID_loadbar = 1'b1;
               ID_EX_flush   = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else if (id_valid) begin
               // A stack fault kills the redirect outright; the pipeline freezes from the next cycle.
               if (id_call) begin
                  if (depth_q == DEPTH_FULL) begin
                     err_d   = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     pc_mux      = 2'b10;
                     push        = 1'b1;
                     IF_ID_flush = 1'b1;
                     depth_d     = depth_q + 1'b1;
                     state_d     = ST_REDIR;
                  end
               end else if (id_ret) begin
                  if (depth_q == '0) begin
                     err_d   = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     pc_mux      = 2'b11;
                     pop         = 1'b1;
                     IF_ID_flush = 1'b1;
                     depth_d     = depth_q - 1'b1;
                     state_d     = ST_REDIR;
                  end
               end else if (id_jump) begin
                  pc_mux      = 2'b10;
                  IF_ID_flush = 1'b1;
                  state_d     = ST_REDIR;
               end else if (id_branch && branch_taken) begin
                  pc_mux      = 2'b01;
                  IF_ID_flush = 1'b1;
                  state_d     = ST_REDIR;
               end
            end
         end
         ST_REDIR: state_d = ST_RUN;
         ST_HALT: begin
            pc_writebar   = 1'b1;
            IF_ID_loadbar = 1'b1;
            ID_EX_flush   = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase

      if (mem_reg_write && (mem_rd == ex_src_a))     forward_A = 2'b10;
      else if (wb_reg_write && (wb_rd == ex_src_a))  forward_A = 2'b11;

      if (ex_use_imm)                                forward_B = 2'b01;
      else if (mem_reg_write && (mem_rd == ex_src_b)) forward_B = 2'b10;
      else if (wb_reg_write && (wb_rd == ex_src_b))  forward_B = 2'b11;

      // Controls are forced quiet while reset is held, independent of decoded inputs.
      if (!reset) begin
         pc_writebar   = 1'b0;
         IF_ID_loadbar = 1'b0;
         ID_EX_flush   = 1'b0;
         IF_ID_flush   = 1'b0;
         pc_mux        = 2'b00;
         push          = 1'b0;
         pop           = 1'b0;
         forward_A     = 2'b00;
         forward_B     = 2'b00;
      end
   end

   assign stack_err   = err_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use and flag stalls,
// redirects, return-stack overflow/underflow and asynchronous reset behaviour.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_use_a, id_use_b;
   logic [2:0]  id_src_a, id_src_b;
   logic        id_branch, id_jump, id_call, id_ret, id_uses_flags, branch_taken;
   logic [2:0]  ex_rd, mem_rd, wb_rd, ex_src_a, ex_src_b;
   logic        ex_reg_write, mem_reg_write, wb_reg_write;
   logic        ex_is_load, ex_writes_flags, ex_use_imm;
   logic        pc_writebar, IF_ID_loadbar, ID_EX_flush, IF_ID_flush;
   logic [1:0]  pc_mux, forward_A, forward_B;
   logic        push, pop, stack_err;
   logic [15:0] stall_count;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STACK_DEPTH(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_use_a(id_use_a), .id_use_b(id_use_b),
      .id_branch(id_branch), .id_jump(id_jump), .id_call(id_call), .id_ret(id_ret),
      .id_uses_flags(id_uses_flags), .branch_taken(branch_taken),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .ex_is_load(ex_is_load), .ex_writes_flags(ex_writes_flags),
      .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_use_imm(ex_use_imm),
      .pc_writebar(pc_writebar), .IF_ID_loadbar(IF_ID_loadbar),
      .ID_EX_flush(ID_EX_flush), .IF_ID_flush(IF_ID_flush),
      .pc_mux(pc_mux), .push(push), .pop(pop),
      .forward_A(forward_A), .forward_B(forward_B),
      .stack_err(stack_err), .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic clr();
      id_valid = 0; id_use_a = 0; id_use_b = 0; id_src_a = 0; id_src_b = 0;
      id_branch = 0; id_jump = 0; id_call = 0; id_ret = 0; id_uses_flags = 0; branch_taken = 0;
      ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_src_a = 0; ex_src_b = 0;
      ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
      ex_is_load = 0; ex_writes_flags = 0; ex_use_imm = 0;
   endtask

   // Move to 1 time unit after the next rising edge; inputs are driven there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      chk({tag, ".pc_writebar"},   pc_writebar,   exp);
      chk({tag, ".IF_ID_loadbar"}, IF_ID_loadbar, exp);
      chk({tag, ".ID_EX_flush"},   ID_EX_flush,   exp);
   endtask

   // Issue n calls, each followed by its REDIR bubble cycle.
   task automatic do_calls(input int n);
      for (int i = 0; i < n; i++) begin
         clr(); id_valid = 1; id_call = 1; #1;
         chk($sformatf("call%0d.push", i), push, 1'b1);
         chk($sformatf("call%0d.pc_mux", i), pc_mux, 2'b10);
         chk($sformatf("call%0d.flush", i), IF_ID_flush, 1'b1);
         tick();
         #1;
         chk($sformatf("call%0d.redir_push", i), push, 1'b0);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      reset = 0;
      // Hazard-inducing inputs while reset is held must leave every control quiet.
      id_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 2; id_use_b = 1; id_src_b = 2;
      mem_reg_write = 1; mem_rd = 3; ex_src_a = 3; ex_src_b = 3; id_call = 1;
      #12;
      chk("rst.pc_writebar", pc_writebar, 1'b0);
      chk("rst.push", push, 1'b0);
      chk("rst.forward_A", forward_A, 2'b00);
      chk("rst.forward_B", forward_B, 2'b00);
      chk("rst.stall_count", stall_count, 16'd0);
      chk("rst.stack_err", stack_err, 1'b0);
      clr();
      #1 reset = 1;
      tick();

      // Forwarding
      mem_reg_write = 1; mem_rd = 3; ex_src_a = 3; ex_src_b = 3; #1;
      chk("fwd.mem_A", forward_A, 2'b10);
      chk("fwd.mem_B", forward_B, 2'b10);
      ex_use_imm = 1; #1;
      chk("fwd.imm_B", forward_B, 2'b01);
      clr(); wb_reg_write = 1; wb_rd = 5; ex_src_a = 5; ex_src_b = 5; mem_reg_write = 1; mem_rd = 4; #1;
      chk("fwd.wb_A", forward_A, 2'b11);
      mem_rd = 5; #1;
      chk("fwd.mem_over_wb_B", forward_B, 2'b10);
      clr(); mem_reg_write = 1; mem_rd = 0; ex_src_a = 0; ex_src_b = 1; #1;
      chk("fwd.r0_A", forward_A, 2'b10);
      chk("fwd.nomatch_B", forward_B, 2'b00);
      mem_reg_write = 0; #1;
      chk("fwd.nowrite_A", forward_A, 2'b00);

      // Load-use: source not in use means no stall
      clr(); id_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 2; id_src_b = 2; #1;
      chk_stall("lu_unused", 1'b0);
      id_use_b = 1; #1;
      chk_stall("lu", 1'b1);
      chk("lu.IF_ID_flush", IF_ID_flush, 1'b0);
      tick();
      ex_is_load = 0; #1;
      chk_stall("lu_after", 1'b0);
      chk("lu.stall_count", stall_count, 16'd1);
      tick();

      // Flag stall then taken branch
      clr(); id_valid = 1; id_branch = 1; id_uses_flags = 1; branch_taken = 1; ex_writes_flags = 1; #1;
      chk_stall("flag", 1'b1);
      chk("flag.pc_mux", pc_mux, 2'b00);
      chk("flag.IF_ID_flush", IF_ID_flush, 1'b0);
      tick();
      ex_writes_flags = 0; #1;
      chk_stall("br", 1'b0);
      chk("br.pc_mux", pc_mux, 2'b01);
      chk("br.IF_ID_flush", IF_ID_flush, 1'b1);
      tick();
      // REDIR: same inputs plus a flag writer; hazard checks and redirects are suppressed
      ex_writes_flags = 1; #1;
      chk_stall("redir", 1'b0);
      chk("redir.pc_mux", pc_mux, 2'b00);
      chk("redir.IF_ID_flush", IF_ID_flush, 1'b0);
      tick();
      ex_writes_flags = 0; branch_taken = 0; #1;
      chk("nt.pc_mux", pc_mux, 2'b00);
      chk("nt.IF_ID_flush", IF_ID_flush, 1'b0);
      chk("redir.stall_count", stall_count, 16'd2);
      tick();

      // Jump
      clr(); id_valid = 1; id_jump = 1; #1;
      chk("jmp.pc_mux", pc_mux, 2'b10);
      chk("jmp.push", push, 1'b0);
      chk("jmp.IF_ID_flush", IF_ID_flush, 1'b1);
      tick();
      clr(); tick();

      // Eight calls fill the stack; the ninth overflows
      do_calls(8);
      clr(); id_valid = 1; id_call = 1; #1;
      chk("ovf.push", push, 1'b0);
      chk("ovf.pc_mux", pc_mux, 2'b00);
      chk("ovf.IF_ID_flush", IF_ID_flush, 1'b0);
      chk("ovf.err_pre", stack_err, 1'b0);
      tick();
      clr(); id_valid = 1; id_jump = 1; #1;
      chk("halt.stack_err", stack_err, 1'b1);
      chk_stall("halt", 1'b1);
      chk("halt.pc_mux", pc_mux, 2'b00);
      tick(); tick();
      chk_stall("halt2", 1'b1);
      chk("halt.stall_count", stall_count, 16'd2);
      reset = 0; #1;
      chk("rst2.stack_err", stack_err, 1'b0);
      chk_stall("rst2", 1'b0);
      #3 reset = 1;
      clr(); tick();

      // Depth is back to 0: eight calls succeed again, then eight rets
      do_calls(8);
      for (int i = 0; i < 8; i++) begin
         clr(); id_valid = 1; id_ret = 1; #1;
         chk($sformatf("ret%0d.pop", i), pop, 1'b1);
         chk($sformatf("ret%0d.pc_mux", i), pc_mux, 2'b11);
         tick();
         clr(); tick();
      end
      chk("rets.stack_err", stack_err, 1'b0);

      // Underflow
      clr(); id_valid = 1; id_ret = 1; #1;
      chk("unf.pop", pop, 1'b0);
      chk("unf.pc_mux", pc_mux, 2'b00);
      tick();
      chk("unf.stack_err", stack_err, 1'b1);
      chk_stall("unf_halt", 1'b1);
      #2 reset = 0;
      mem_reg_write = 1; mem_rd = 1; ex_src_a = 1; #1;
      chk_stall("rst3", 1'b0);
      chk("rst3.stack_err", stack_err, 1'b0);
      chk("rst3.forward_A", forward_A, 2'b00);
      chk("rst3.pop", pop, 1'b0);
      #2 reset = 1; #1;
      chk_stall("rst3_run", 1'b0);
      chk("rst3_run.forward_A", forward_A, 2'b10);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
